// File: rtl/reg_spill_ctrl.sv
// Register-file spill/fill sequencer: copies every register to a fixed memory window and back.
// Optional build macro SPILL_SKIP_COUT_EN leaves the top register (COUT) out of both sequences.
module reg_spill_ctrl #(
   parameter int unsigned   count     = 3,
   parameter int unsigned   DW        = 8,
   parameter int unsigned   AW        = 8,
   parameter logic [AW-1:0] BASE_ADDR = AW'(8'hF0)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             save_req,
   input  logic             restore_req,
   output logic             busy,
   output logic             done,
   output logic [count-1:0] rf_rd_addr,
   input  logic [DW-1:0]    rf_rd_data,
   output logic             rf_wr_en,
   output logic [count-1:0] rf_wr_addr,
   output logic [DW-1:0]    rf_wr_data,
   output logic [AW-1:0]    mem_addr,
   output logic             mem_wr_en,
   output logic [DW-1:0]    mem_wr_data,
   output logic             mem_rd_en,
   input  logic [DW-1:0]    mem_rd_data
);

   localparam int unsigned IW   = count + 1;
   localparam int unsigned NREG = 1 << count;
`ifdef SPILL_SKIP_COUT_EN
   localparam int unsigned NSEQ = NREG - 1;
`else
   localparam int unsigned NSEQ = NREG;
`endif
   localparam logic [IW-1:0] LAST_IDX  = IW'(NSEQ - 1);
   localparam logic [IW-1:0] FINAL_IDX = IW'(NSEQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_next;
   logic [AW-1:0] slot_addr;

   // Spill slot for the current index; wraps modulo 2**AW past the top of memory.
   assign slot_addr = BASE_ADDR + AW'(idx);

   // State and index registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // Next state and port drive
   always_comb begin
      state_next  = state;
      idx_next    = idx;
      busy        = 1'b0;
      done        = 1'b0;
      rf_rd_addr  = '0;
      rf_wr_en    = 1'b0;
      rf_wr_addr  = '0;
      rf_wr_data  = '0;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      mem_rd_en   = 1'b0;

      unique case (state)
         IDLE: begin
            if (save_req) begin
               state_next = SAVE;
               idx_next   = '0;
            end else if (restore_req) begin
               state_next = RESTORE;
               idx_next   = '0;
            end
         end

         SAVE: begin
            busy        = 1'b1;
            rf_rd_addr  = count'(idx);
            mem_wr_en   = 1'b1;
            mem_addr    = slot_addr;
            mem_wr_data = rf_rd_data;
            if (idx == LAST_IDX) begin
               state_next = DONE;
               idx_next   = '0;
            end else begin
               idx_next = idx + IW'(1);
            end
         end

         // Read slot j while writing register j-1 from the previous cycle's read data.
         RESTORE: begin
            busy = 1'b1;
            if (idx < FINAL_IDX) begin
               mem_rd_en = 1'b1;
               mem_addr  = slot_addr;
            end
            if (idx != '0) begin
               rf_wr_en   = 1'b1;
               rf_wr_addr = count'(idx - IW'(1));
               rf_wr_data = mem_rd_data;
            end
            if (idx == FINAL_IDX) begin
               state_next = DONE;
               idx_next   = '0;
            end else begin
               idx_next = idx + IW'(1);
            end
         end

         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

endmodule
